// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Used by keypad_scanner; the auto-repeat feature there is gated by KEYPAD_REPEAT_EN.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int LINES = 4;
    localparam logic [LINES-1:0] DRIVE_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // Index of the lowest active-low sense bit (0 when none is low).
    function automatic logic [1:0] lowest_low(input logic [LINES-1:0] s_n);
        lowest_low = 2'd0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (!s_n[i]) lowest_low = 2'(i);
        end
    endfunction

    function automatic logic [LINES-1:0] drive_decode(input logic [1:0] idx);
        drive_decode = ~(LINES'(1) << idx);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic-width two-flop synchronizer; resets to all-ones so idle
// active-low inputs read as inactive.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-period debounce and a one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to enable auto-repeat strobes while a key is held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 5000,
    parameter int DB_SCANS     = 4,
    parameter int REPEAT_SCANS = 100
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [LINES-1:0] sense_n,
    output logic [LINES-1:0] drive_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DB_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DB_SCANS - 1);
    localparam logic [CW-1:0] DB_ONE     = CW'(1);

    if (SCAN_DIV < 4 || DB_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
        $error("keypad_scanner: illegal parameter value");
    end

    logic [LINES-1:0] w_sense_sync;
    logic             w_sample;
    logic [1:0]       w_low_idx;
    logic             w_any_low;
    logic             w_latched_low;

    logic [DW-1:0]    r_dwell;
    state_t           r_state,      w_state_next;
    logic [1:0]       r_drive_idx,  w_drive_idx_next;
    logic [LINES-1:0] r_drive_n;
    logic [KEY_W-1:0] r_key_code,   w_key_code_next;
    logic             r_key_valid,  w_key_valid_next;
    logic             r_key_held,   w_key_held_next;
    logic [CW-1:0]    r_db_cnt,     w_db_cnt_next;

    sync_2ff #(
        .W (LINES)
    ) u_sense_sync (
        .clk     (clk),
        .rst_n   (clr_n),
        .i_async (sense_n),
        .o_sync  (w_sense_sync)
    );

    assign w_sample      = (r_dwell == DWELL_LAST);
    assign w_any_low     = ~&w_sense_sync;
    assign w_low_idx     = lowest_low(w_sense_sync);
    assign w_latched_low = ~w_sense_sync[r_key_code[1:0]];

    // Free-running dwell: every state samples on the same SCAN_DIV grid.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_dwell <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_SCANS - 1);

    logic [RW-1:0] r_rpt_cnt, w_rpt_cnt_next;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rpt_cnt <= '0;
        end else begin
            r_rpt_cnt <= w_rpt_cnt_next;
        end
    end
`endif

    always_comb begin
        w_state_next     = r_state;
        w_drive_idx_next = r_drive_idx;
        w_key_code_next  = r_key_code;
        w_key_valid_next = 1'b0;
        w_key_held_next  = r_key_held;
        w_db_cnt_next    = r_db_cnt;
`ifdef KEYPAD_REPEAT_EN
        w_rpt_cnt_next   = r_rpt_cnt;
`endif
        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    if (w_any_low) begin
                        w_key_code_next = {r_drive_idx, w_low_idx};
                        if (DB_SCANS == 1) begin
                            w_key_valid_next = 1'b1;
                            w_key_held_next  = 1'b1;
                            w_db_cnt_next    = '0;
                            w_state_next     = HELD;
`ifdef KEYPAD_REPEAT_EN
                            w_rpt_cnt_next   = '0;
`endif
                        end else begin
                            w_db_cnt_next = DB_ONE;
                            w_state_next  = DEBOUNCE;
                        end
                    end else begin
                        w_drive_idx_next = r_drive_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_latched_low) begin
                        if (r_db_cnt == DB_LAST) begin
                            w_key_valid_next = 1'b1;
                            w_key_held_next  = 1'b1;
                            w_db_cnt_next    = '0;
                            w_state_next     = HELD;
`ifdef KEYPAD_REPEAT_EN
                            w_rpt_cnt_next   = '0;
`endif
                        end else begin
                            w_db_cnt_next = r_db_cnt + DB_ONE;
                        end
                    end else begin
                        w_db_cnt_next    = '0;
                        w_drive_idx_next = r_drive_idx + 2'd1;
                        w_state_next     = SCAN;
                    end
                end
                HELD: begin
                    if (!w_latched_low) begin
`ifdef KEYPAD_REPEAT_EN
                        w_rpt_cnt_next = '0;
`endif
                        if (DB_SCANS == 1) begin
                            w_key_held_next  = 1'b0;
                            w_db_cnt_next    = '0;
                            w_drive_idx_next = r_drive_idx + 2'd1;
                            w_state_next     = SCAN;
                        end else begin
                            w_db_cnt_next = DB_ONE;
                            w_state_next  = RELEASE;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (r_rpt_cnt == RPT_LAST) begin
                        w_key_valid_next = 1'b1;
                        w_rpt_cnt_next   = '0;
                    end else begin
                        w_rpt_cnt_next = r_rpt_cnt + RW'(1);
                    end
`endif
                end
                RELEASE: begin
                    if (!w_latched_low) begin
                        if (r_db_cnt == DB_LAST) begin
                            w_key_held_next  = 1'b0;
                            w_db_cnt_next    = '0;
                            w_drive_idx_next = r_drive_idx + 2'd1;
                            w_state_next     = SCAN;
                        end else begin
                            w_db_cnt_next = r_db_cnt + DB_ONE;
                        end
                    end else begin
                        w_db_cnt_next = '0;
                        w_state_next  = HELD;
`ifdef KEYPAD_REPEAT_EN
                        w_rpt_cnt_next = '0;
`endif
                    end
                end
                default: begin
                    w_state_next = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= SCAN;
            r_drive_idx <= 2'd0;
            r_drive_n   <= DRIVE_IDLE;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_db_cnt    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drive_idx <= w_drive_idx_next;
            r_drive_n   <= drive_decode(w_drive_idx_next);
            r_key_code  <= w_key_code_next;
            r_key_valid <= w_key_valid_next;
            r_key_held  <= w_key_held_next;
            r_db_cnt    <= w_db_cnt_next;
        end
    end

    assign drive_n   = r_drive_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a matrix model drives sense_n, expected
// key codes are queued at stimulus time and popped on each key_valid strobe.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DB_SCANS     = 3;
    localparam int REPEAT_SCANS = 5;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [3:0]  sense_n;
    logic [3:0]  drive_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    logic [3:0]  exp_q[$];

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DB_SCANS     (DB_SCANS),
        .REPEAT_SCANS (REPEAT_SCANS)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .sense_n   (sense_n),
        .drive_n   (drive_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its sense line low while its drive line is low.
    always_comb begin
        sense_n = 4'hF;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 4; s++) begin
                if (pressed[d*4+s] && !drive_n[d]) sense_n[s] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (clr_n && key_valid) begin
            $display("strobe: key_code=%h held=%0d cyc=%0d", key_code, key_held, cyc);
            if (exp_q.size() == 0) begin
                chk("spurious_strobe", 1, 0);
            end else begin
                chk("strobe_code", key_code, exp_q.pop_front());
                chk("held_at_strobe", key_held, 1);
            end
        end
    end

    function automatic logic [3:0] exp_drive(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << ((c / 4) % 4));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [15:0] keys);
        clr_n   = 1'b0;
        pressed = keys;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        // Reset values and idle scan sequence
        repeat (3) @(posedge clk);
        #1;
        chk("rst_drive", drive_n, 4'b1110);
        chk("rst_code", key_code, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_held", key_held, 0);
        @(negedge clk);
        clr_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("idle_drive", drive_n, exp_drive(cyc));
            chk("idle_valid", key_valid, 0);
        end

        // Key d0/s2 held from reset, released after cycle 20
        do_reset(16'h0004);
        exp_q.push_back(4'h2);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("press_valid_time", key_valid, int'(cyc == 12));
            if (cyc == 12) chk("press_code", key_code, 4'h2);
            if (cyc >= 12) chk("press_held", key_held, int'(cyc < 32));
            if (cyc == 20) pressed = '0;
        end

        // Bounce on d3/s1: one-sample contact, then a steady press
        do_reset('0);
        exp_q.push_back(4'hD);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("bounce_valid_time", key_valid, int'(cyc == 44));
            if (cyc == 12) pressed[13] = 1'b1;
            if (cyc == 16) pressed[13] = 1'b0;
            if (cyc == 21) pressed[13] = 1'b1;
        end

        // Two keys on drive 2: lowest sense wins, other sense ignored while held
        do_reset(16'h0900);
        exp_q.push_back(4'h8);
        if (REP) exp_q.push_back(4'h8);
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("two_valid_time", key_valid, int'(cyc == 20 || (REP && cyc == 40)));
            if (cyc >= 20) chk("two_held", key_held, int'(cyc < 60));
            if (cyc == 22) pressed[11] = 1'b0;
            if (cyc == 48) pressed[8]  = 1'b0;
        end

        // Asynchronous reset in DEBOUNCE after two samples, then re-debounce
        do_reset(16'h0002);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (cyc == 8) chk("mid_code_latched", key_code, 4'h1);
            chk("mid_no_valid", key_valid, 0);
        end
        #2;
        clr_n = 1'b0;
        #1;
        chk("mid_rst_drive", drive_n, 4'b1110);
        chk("mid_rst_code", key_code, 0);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_held", key_held, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        cyc   = 0;
        exp_q.push_back(4'h1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("redb_valid_time", key_valid, int'(cyc == 12));
        end

        // Long hold on d1/s1: single strobe, or a strobe every 20 cycles with repeat
        do_reset(16'h0020);
        exp_q.push_back(4'h5);
        if (REP) begin
            exp_q.push_back(4'h5);
            exp_q.push_back(4'h5);
        end
        for (int i = 0; i < 70; i++) begin
            tick();
            chk("hold_valid_time", key_valid,
                int'(cyc == 16 || (REP && (cyc == 36 || cyc == 56))));
        end
        pressed = '0;
        repeat (20) tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad reader for the board front end: scans a 4x4 key matrix by driving one line low at a time, samples the four sense lines, debounces in scan-period units, and reports each accepted press as a 4-bit key code with a one-cycle strobe. It is the input-side counterpart of the multiplexed seven-segment scan path. It replaces the raw switch and button inputs feeding the counter and loader.

## Interface
- SCAN_DIV, default 5000: clk cycles each drive line is held; must be ≥ 4.
- DB_SCANS, default 4: consecutive identical samples required to accept a press or release; must be ≥ 1.
- REPEAT_SCANS, default 100: samples between auto-repeat strobes while held; used only with KEYPAD_REPEAT_EN.
- clk  input  1  system clock, 100 MHz; all logic on posedge.
- clr_n  input  1  asynchronous, active-low reset.
- sense_n  input  4  matrix sense lines, active-low, externally pulled up, asynchronous to clk.
- drive_n  output  4  matrix drive lines, one-cold; bit i low selects drive line i.
- key_code  output  4  {drive index[1:0], sense index[1:0]} of the last accepted key.
- key_valid  output  1  one-cycle strobe on key acceptance (and on repeat when enabled).
- key_held  output  1  high from acceptance until debounced release.

## Operation
- sense_n passes through a 2-flop synchronizer (reset to 4'b1111); all decisions use the synchronized value.
- Dwell counter runs 0..SCAN_DIV-1 per drive line; one sample is taken when it equals SCAN_DIV-1.
- States:
  - SCAN: at each sample, if any sense bit is low, latch drive index and lowest low sense index into key_code, set sample count to 1, keep the current drive line, go DEBOUNCE. Otherwise advance drive index 0→1→2→3→0.
  - DEBOUNCE: the latched sense bit low at a sample increments the count. When the count reaches DB_SCANS, pulse key_valid, set key_held, go HELD. A high sample returns to SCAN and advances the drive index. If DB_SCANS=1, acceptance happens from SCAN directly.
  - HELD: a high sample on the latched bit sets release count to 1 and goes RELEASE. Other sense bits are ignored.
  - RELEASE: a high sample increments the count. At DB_SCANS, clear key_held and go SCAN with the drive index advanced. A low sample returns to HELD.
- Multiple keys on the same drive line: the lowest sense index wins. Keys on other drive lines are invisible until a return to SCAN. No ghost rejection.
- key_code holds its value until the next latch in SCAN. It may change while key_held is 0 and key_valid is 0.
- Reset values: state SCAN, drive index 0, drive_n 4'b1110, key_code 4'h0, key_valid 0, key_held 0, all counters 0.
- A reset during any state returns immediately to the reset values. No strobe is emitted on or after reset until a fresh debounce completes.

## Timing
- key_valid is registered. It asserts on the clk edge after the DB_SCANS-th qualifying sample and lasts exactly one cycle.
- A key held from before reset on drive line 0: key_valid is high in cycle DB_SCANS·SCAN_DIV, counting the first edge after clr_n deasserts as cycle 1.
- Worst-case press latency is (3 + DB_SCANS)·SCAN_DIV + 2 cycles.
- Release latency is DB_SCANS·SCAN_DIV + 2 cycles maximum.
- drive_n changes only on the cycle after a sample. Each line is driven for exactly SCAN_DIV cycles while in SCAN.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter increments on each low sample.
  - At REPEAT_SCANS, key_valid pulses again with an unchanged key_code, and the counter restarts at 0.
  - The counter clears on entry to HELD and on going to RELEASE.
- KEYPAD_REPEAT_EN undefined: exactly one key_valid per accepted press. REPEAT_SCANS is ignored and no repeat counter exists.

## Structure
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - KEY_W = 4 and LINES = 4;
  - DRIVE_IDLE = 4'b1110.
- Counter widths are derived in RTL with $clog2 of the parameters.
- One sub-module, sync_2ff: a generic-width 2-flop synchronizer with asynchronous active-low reset to all-ones, instantiated on sense_n.

## Test plan
Bench parameters: SCAN_DIV=4, DB_SCANS=3, REPEAT_SCANS=5.
- Reset: clr_n low for 3 cycles → drive_n=4'b1110, key_code=0, key_valid=0, key_held=0. Release it with all sense lines high, run 40 cycles → drive_n cycles 1110→1101→1011→0111→1110, 4 cycles each, and key_valid never asserts.
- Pressed key:
  - Stimulus: key at drive 0 / sense 2 held from reset.
  - key_valid is high only in cycle 12 and key_code=4'h2.
  - key_held rises in cycle 12 and falls 12 cycles after the last low sample once the key is released.
- Bounce: key at drive 3 / sense 1 low for 1 sample, high for 1, then low steady → the first contact produces no strobe. After the steady press, one strobe with key_code=4'hD.
- Two keys: drive 2 sense 0 and sense 3 pressed together → key_code=4'h8. Release sense 0 only → key_held stays 1 and no new strobe.
- Reset mid-operation: assert clr_n in DEBOUNCE after 2 samples → the reset values appear asynchronously. Re-debounce after release → strobe 12 cycles later.
- Repeat:
  - With KEYPAD_REPEAT_EN, holding drive 1 / sense 1 → strobes at acceptance, then every 20 cycles, with key_code=4'h5.
  - Without the macro → a single strobe.
